id_stage: RTL

Instruction-decode stage that sits directly downstream of the IF stage and consumes its `inst`/`pc` outputs.
- Holds the IF/ID pipeline latch and the 32x32 register file with write-back bypass.
- Detects load-use hazards and stalls IF when one is found.
- Drops the instruction in flight on a taken branch.
- Drives a registered ID/EX bundle to the execute stage.
- Instruction format: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], imm[15:0].

---
 rtl/id_stage.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_stage
// Brief    : Instruction-decode stage. IF/ID latch, 32x32 register file with
//            write-back bypass, load-use hazard stall, flush bubble and a
//            registered ID/EX bundle.
// Revision : 1.0 - initial release
// ============================================================================
module id_stage #(
    parameter int          PC_W    = 11,
    parameter int          DATA_W  = 32,
    parameter logic [5:0]  LOAD_OP = 6'h23
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] inst,
    input  logic [PC_W-1:0]   pc,
    input  logic              flush,
    input  logic              ex_mem_read,
    input  logic [4:0]        ex_rt,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              stall,
    output logic              id_valid,
    output logic [PC_W-1:0]   id_pc,
    output logic [5:0]        id_opcode,
    output logic [4:0]        id_rs_addr,
    output logic [4:0]        id_rt_addr,
    output logic [4:0]        id_rd_addr,
    output logic [DATA_W-1:0] id_rs_data,
    output logic [DATA_W-1:0] id_rt_data,
    output logic [DATA_W-1:0] id_imm,
    output logic              id_mem_read
);

    localparam int c_NUM_REGS = 32;

    // IF/ID latch
    logic [DATA_W-1:0] r_inst;
    logic [PC_W-1:0]   r_pc;
    logic              r_valid;

    // Register file
    logic [DATA_W-1:0] r_regs [c_NUM_REGS];

    // ID/EX bundle
    logic              r_id_valid;
    logic [PC_W-1:0]   r_id_pc;
    logic [5:0]        r_id_opcode;
    logic [4:0]        r_id_rs_addr;
    logic [4:0]        r_id_rt_addr;
    logic [4:0]        r_id_rd_addr;
    logic [DATA_W-1:0] r_id_rs_data;
    logic [DATA_W-1:0] r_id_rt_data;
    logic [DATA_W-1:0] r_id_imm;
    logic              r_id_mem_read;

    // Decode of the latched instruction
    logic [5:0]        w_opcode;
    logic [4:0]        w_rs_addr;
    logic [4:0]        w_rt_addr;
    logic [4:0]        w_rd_addr;
    logic [15:0]       w_imm16;
    logic [DATA_W-1:0] w_imm;
    logic [DATA_W-1:0] w_rs_data;
    logic [DATA_W-1:0] w_rt_data;
    logic              w_hazard;
    logic              w_stall;
    logic              w_issue;

    assign w_opcode  = r_inst[31:26];
    assign w_rs_addr = r_inst[25:21];
    assign w_rt_addr = r_inst[20:16];
    assign w_rd_addr = r_inst[15:11];
    assign w_imm16   = r_inst[15:0];
    assign w_imm     = {{(DATA_W-16){w_imm16[15]}}, w_imm16};

    // r0 is hard-wired to zero; a same-cycle write-back is forwarded so the
    // operand never sees the stale register value.
    assign w_rs_data = (w_rs_addr == 5'd0)                   ? '0      :
                       (wb_en && (wb_addr == w_rs_addr))     ? wb_data :
                                                               r_regs[w_rs_addr];
    assign w_rt_data = (w_rt_addr == 5'd0)                   ? '0      :
                       (wb_en && (wb_addr == w_rt_addr))     ? wb_data :
                                                               r_regs[w_rt_addr];

    // Load-use: the load in EX produces its result too late for this
    // instruction, so hold it one cycle. A flush kills it anyway.
    assign w_hazard = r_valid & ex_mem_read & (ex_rt != 5'd0) &
                      ((ex_rt == w_rs_addr) | (ex_rt == w_rt_addr));
    assign w_stall  = w_hazard & ~flush;
    assign w_issue  = r_valid & ~flush & ~w_stall;

    assign stall = w_stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inst  <= '0;
            r_pc    <= '0;
            r_valid <= 1'b0;
        end else if (flush) begin
            r_inst  <= '0;
            r_valid <= 1'b0;
        end else if (!w_stall) begin
            r_inst  <= inst;
            r_pc    <= pc;
            r_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wb_en && (wb_addr != 5'd0)) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    // Bubbles are fully zeroed so downstream never sees stale fields.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_id_valid    <= 1'b0;
            r_id_pc       <= '0;
            r_id_opcode   <= '0;
            r_id_rs_addr  <= '0;
            r_id_rt_addr  <= '0;
            r_id_rd_addr  <= '0;
            r_id_rs_data  <= '0;
            r_id_rt_data  <= '0;
            r_id_imm      <= '0;
            r_id_mem_read <= 1'b0;
        end else if (!w_issue) begin
            r_id_valid    <= 1'b0;
            r_id_pc       <= '0;
            r_id_opcode   <= '0;
            r_id_rs_addr  <= '0;
            r_id_rt_addr  <= '0;
            r_id_rd_addr  <= '0;
            r_id_rs_data  <= '0;
            r_id_rt_data  <= '0;
            r_id_imm      <= '0;
            r_id_mem_read <= 1'b0;
        end else begin
            r_id_valid    <= 1'b1;
            r_id_pc       <= r_pc;
            r_id_opcode   <= w_opcode;
            r_id_rs_addr  <= w_rs_addr;
            r_id_rt_addr  <= w_rt_addr;
            r_id_rd_addr  <= w_rd_addr;
            r_id_rs_data  <= w_rs_data;
            r_id_rt_data  <= w_rt_data;
            r_id_imm      <= w_imm;
            r_id_mem_read <= (w_opcode == LOAD_OP);
        end
    end

    assign id_valid    = r_id_valid;
    assign id_pc       = r_id_pc;
    assign id_opcode   = r_id_opcode;
    assign id_rs_addr  = r_id_rs_addr;
    assign id_rt_addr  = r_id_rt_addr;
    assign id_rd_addr  = r_id_rd_addr;
    assign id_rs_data  = r_id_rs_data;
    assign id_rt_data  = r_id_rt_data;
    assign id_imm      = r_id_imm;
    assign id_mem_read = r_id_mem_read;

endmodule
`default_nettype wire
